// File: rtl/ddr_arb_pkg.sv
// Shared types and command encodings for the DDR native command arbiter.
package ddr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_PHASE = 2'd1,
    RD_PHASE = 2'd2
  } arb_state_e;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

endpackage

// File: rtl/ddr_wdf_credit_cnt.sv
// Write-data credit counter: +1 per completed write-data burst, -1 per write command
// grant, saturating at all-ones with a sticky overflow flag.
module ddr_wdf_credit_cnt #(
  parameter int CREDIT_WIDTH = 6
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    beat_done_i,
  input  logic                    wr_grant_i,
  output logic [CREDIT_WIDTH-1:0] credit_o,
  output logic                    credit_ovf_o
);

  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = '1;
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_ONE = CREDIT_WIDTH'(1);

  logic [CREDIT_WIDTH-1:0] credit_q, credit_d;
  logic                    ovf_q, ovf_d;

  always_comb begin
    credit_d = credit_q;
    ovf_d    = ovf_q;
    if (beat_done_i && !wr_grant_i) begin
      if (credit_q == CREDIT_MAX) ovf_d = 1'b1;
      else                        credit_d = credit_q + CREDIT_ONE;
    end else if (!beat_done_i && wr_grant_i && (credit_q != '0)) begin
      credit_d = credit_q - CREDIT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      credit_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      ovf_q    <= ovf_d;
    end
  end

  assign credit_o     = credit_q;
  assign credit_ovf_o = ovf_q;

endmodule

// File: rtl/ddr_native_cmd_arbiter.sv
// Read/write command arbiter in front of the MIG native app_* command port.
// Optional grant statistics outputs are compiled in with DDR_ARB_STATS_EN.
module ddr_native_cmd_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 27,
  parameter int MAX_BURST    = 16,
  parameter int CREDIT_WIDTH = 6
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  init_calib_complete,
  input  logic                  wr_req_vld,
  input  logic [ADDR_WIDTH-1:0] wr_req_addr,
  output logic                  wr_req_rdy,
  input  logic                  rd_req_vld,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr,
  output logic                  rd_req_rdy,
  input  logic                  wdf_beat_done,
  output logic                  app_en,
  output logic [2:0]            app_cmd,
  output logic [ADDR_WIDTH-1:0] app_addr,
  input  logic                  app_rdy,
`ifdef DDR_ARB_STATS_EN
  output logic [31:0]           wr_grant_cnt,
  output logic [31:0]           rd_grant_cnt,
`endif
  output logic                  credit_ovf
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [BW-1:0] BURST_ONE = BW'(1);

  arb_state_e              state_q, state_d;
  logic [BW-1:0]           burst_q, burst_d;
  logic                    app_en_q;
  logic [2:0]              app_cmd_q;
  logic [ADDR_WIDTH-1:0]   app_addr_q;
  logic [CREDIT_WIDTH-1:0] credit;
  logic                    slot_free, can_grant, wr_elig, rd_elig, burst_room;
  logic                    grant_wr, grant_rd;

  assign slot_free  = !app_en_q || app_rdy;
  assign can_grant  = rst_n && init_calib_complete && slot_free;
  // A write may borrow the credit arriving in this very cycle.
  assign wr_elig    = wr_req_vld && ((credit != '0) || wdf_beat_done);
  assign rd_elig    = rd_req_vld;
  assign burst_room = burst_q < BURST_MAX;

  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    state_d  = state_q;
    burst_d  = burst_q;
    if (can_grant) begin
      case (state_q)
        WR_PHASE: begin
          if (wr_elig && burst_room) grant_wr = 1'b1;
          else if (rd_elig)          grant_rd = 1'b1;
          else if (wr_elig)          grant_wr = 1'b1;
        end
        RD_PHASE: begin
          if (rd_elig && burst_room) grant_rd = 1'b1;
          else if (wr_elig)          grant_wr = 1'b1;
          else if (rd_elig)          grant_rd = 1'b1;
        end
        default: begin
          if (rd_elig)      grant_rd = 1'b1;
          else if (wr_elig) grant_wr = 1'b1;
        end
      endcase
    end
    if (grant_wr) begin
      state_d = WR_PHASE;
      burst_d = (state_q == WR_PHASE && burst_room) ? burst_q + BURST_ONE : BURST_ONE;
    end else if (grant_rd) begin
      state_d = RD_PHASE;
      burst_d = (state_q == RD_PHASE && burst_room) ? burst_q + BURST_ONE : BURST_ONE;
    end else if (slot_free && !wr_elig && !rd_elig) begin
      state_d = IDLE;
      burst_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      burst_q    <= '0;
      app_en_q   <= 1'b0;
      app_cmd_q  <= CMD_WR;
      app_addr_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      if (grant_wr) begin
        app_en_q   <= 1'b1;
        app_cmd_q  <= CMD_WR;
        app_addr_q <= wr_req_addr;
      end else if (grant_rd) begin
        app_en_q   <= 1'b1;
        app_cmd_q  <= CMD_RD;
        app_addr_q <= rd_req_addr;
      end else if (app_rdy) begin
        app_en_q   <= 1'b0;
      end
    end
  end

  ddr_wdf_credit_cnt #(
    .CREDIT_WIDTH (CREDIT_WIDTH)
  ) u_credit (
    .clock        (clock),
    .rst_n        (rst_n),
    .beat_done_i  (wdf_beat_done),
    .wr_grant_i   (grant_wr),
    .credit_o     (credit),
    .credit_ovf_o (credit_ovf)
  );

`ifdef DDR_ARB_STATS_EN
  logic [31:0] wr_cnt_q, rd_cnt_q;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (grant_wr) wr_cnt_q <= wr_cnt_q + 32'd1;
      if (grant_rd) rd_cnt_q <= rd_cnt_q + 32'd1;
    end
  end

  assign wr_grant_cnt = wr_cnt_q;
  assign rd_grant_cnt = rd_cnt_q;
`endif

  assign wr_req_rdy = grant_wr;
  assign rd_req_rdy = grant_rd;
  assign app_en     = app_en_q;
  assign app_cmd    = app_cmd_q;
  assign app_addr   = app_addr_q;

endmodule

// File: tb/tb_ddr_native_cmd_arbiter.sv
// Directed self-checking bench: single-grant vector table plus multi-cycle sequences.
module tb_ddr_native_cmd_arbiter;
  import ddr_arb_pkg::*;

  localparam int AW = 27;

  logic          clock, rst_n, init_calib_complete;
  logic          wr_req_vld, wr_req_rdy, rd_req_vld, rd_req_rdy;
  logic [AW-1:0] wr_req_addr, rd_req_addr, app_addr;
  logic          wdf_beat_done, app_en, app_rdy, credit_ovf;
  logic [2:0]    app_cmd;
`ifdef DDR_ARB_STATS_EN
  logic [31:0]   wr_grant_cnt, rd_grant_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  ddr_native_cmd_arbiter #(
    .ADDR_WIDTH(AW), .MAX_BURST(16), .CREDIT_WIDTH(6)
  ) dut (
    .clock               (clock),
    .rst_n               (rst_n),
    .init_calib_complete (init_calib_complete),
    .wr_req_vld          (wr_req_vld),
    .wr_req_addr         (wr_req_addr),
    .wr_req_rdy          (wr_req_rdy),
    .rd_req_vld          (rd_req_vld),
    .rd_req_addr         (rd_req_addr),
    .rd_req_rdy          (rd_req_rdy),
    .wdf_beat_done       (wdf_beat_done),
    .app_en              (app_en),
    .app_cmd             (app_cmd),
    .app_addr            (app_addr),
    .app_rdy             (app_rdy),
`ifdef DDR_ARB_STATS_EN
    .wr_grant_cnt        (wr_grant_cnt),
    .rd_grant_cnt        (rd_grant_cnt),
`endif
    .credit_ovf          (credit_ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic          calib, wr_vld, rd_vld, beat;
    logic          exp_wr_rdy, exp_rd_rdy, exp_en;
    logic [2:0]    exp_cmd;
    logic [AW-1:0] exp_addr;
  } vec_t;

  localparam logic [AW-1:0] WA = 27'h0AA;
  localparam logic [AW-1:0] RA = 27'h155;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    init_calib_complete = 1'b0;
    wr_req_vld = 1'b0; wr_req_addr = '0;
    rd_req_vld = 1'b0; rd_req_addr = '0;
    wdf_beat_done = 1'b0; app_rdy = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst_n = 1'b0;
    clear_inputs();
    @(posedge clock);
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n = 1'b0;
    clear_inputs();

    //             calib wr rd beat  wrdy rrdy en  cmd     addr
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CMD_WR, 27'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, CMD_RD, RA};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CMD_WR, 27'h0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, CMD_WR, WA};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, CMD_RD, RA};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, CMD_WR, 27'h0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, CMD_WR, 27'h0};

    // reset state
    do_reset();
    #1;
    chk("rst_app_en", 32'(app_en), 32'd0);
    chk("rst_app_addr", 32'(app_addr), 32'd0);
    chk("rst_ovf", 32'(credit_ovf), 32'd0);

    // single-grant vectors from a fresh reset
    for (int v = 0; v < 7; v++) begin
      do_reset();
      init_calib_complete = vecs[v].calib;
      wr_req_vld = vecs[v].wr_vld; wr_req_addr = WA;
      rd_req_vld = vecs[v].rd_vld; rd_req_addr = RA;
      wdf_beat_done = vecs[v].beat; app_rdy = 1'b1;
      #1;
      chk($sformatf("vec%0d_wr_rdy", v), 32'(wr_req_rdy), 32'(vecs[v].exp_wr_rdy));
      chk($sformatf("vec%0d_rd_rdy", v), 32'(rd_req_rdy), 32'(vecs[v].exp_rd_rdy));
      @(posedge clock); #1;
      chk($sformatf("vec%0d_app_en", v), 32'(app_en), 32'(vecs[v].exp_en));
      chk($sformatf("vec%0d_app_cmd", v), 32'(app_cmd), 32'(vecs[v].exp_cmd));
      chk($sformatf("vec%0d_app_addr", v), 32'(app_addr), 32'(vecs[v].exp_addr));
      $display("[TB] vector %0d: wr_rdy=%0b rd_rdy=%0b app_en=%0b app_cmd=%0d", v,
               wr_req_rdy, rd_req_rdy, app_en, app_cmd);
    end

    // calibration gate: nothing granted until calib rises
    do_reset();
    rd_req_vld = 1'b1; rd_req_addr = 27'h55; app_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("calib_lo_rd_rdy", 32'(rd_req_rdy), 32'd0);
      chk("calib_lo_app_en", 32'(app_en), 32'd0);
      @(negedge clock);
    end
    init_calib_complete = 1'b1;
    #1;
    chk("calib_hi_rd_rdy", 32'(rd_req_rdy), 32'd1);
    @(posedge clock); #1;
    chk("calib_hi_app_en", 32'(app_en), 32'd1);
    chk("calib_hi_app_cmd", 32'(app_cmd), 32'(CMD_RD));
    $display("[TB] calib gate: app_en=%0b app_cmd=%0d", app_en, app_cmd);

    // burst limit: one credit available, both requesters valid
    do_reset();
    init_calib_complete = 1'b1; wdf_beat_done = 1'b1;
    @(negedge clock);
    wdf_beat_done = 1'b0;
    chk("burst_credit_pre", 32'(dut.u_credit.credit_q), 32'd1);
    wr_req_vld = 1'b1; wr_req_addr = WA;
    rd_req_vld = 1'b1; rd_req_addr = RA; app_rdy = 1'b1;
    for (int i = 0; i < 33; i++) begin
      #1;
      chk($sformatf("burst_grant%0d", i), 32'({wr_req_rdy, rd_req_rdy}),
          (i == 16) ? 32'd2 : 32'd1);
      @(negedge clock);
    end
`ifdef DDR_ARB_STATS_EN
    chk("stats_wr", wr_grant_cnt, 32'd1);
    chk("stats_rd", rd_grant_cnt, 32'd32);
`endif
    $display("[TB] burst sequence: 33 grants observed");

    // write blocked on zero credit, enabled by same-cycle beat
    do_reset();
    init_calib_complete = 1'b1; wr_req_vld = 1'b1; wr_req_addr = 27'h2A; app_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("nocredit_wr_rdy", 32'(wr_req_rdy), 32'd0);
      chk("nocredit_app_en", 32'(app_en), 32'd0);
      @(negedge clock);
    end
    wdf_beat_done = 1'b1;
    #1;
    chk("beat_wr_rdy", 32'(wr_req_rdy), 32'd1);
    @(posedge clock); #1;
    chk("beat_app_en", 32'(app_en), 32'd1);
    chk("beat_app_cmd", 32'(app_cmd), 32'(CMD_WR));
    chk("beat_app_addr", 32'(app_addr), 32'h2A);
    chk("beat_credit", 32'(dut.u_credit.credit_q), 32'd0);
    @(negedge clock);
    wdf_beat_done = 1'b0;
    #1;
    chk("after_beat_wr_rdy", 32'(wr_req_rdy), 32'd0);
    $display("[TB] credit borrow: write issued with credit=%0d", dut.u_credit.credit_q);

    // app_rdy backpressure holds the slot
    do_reset();
    init_calib_complete = 1'b1; rd_req_vld = 1'b1; rd_req_addr = 27'h123; app_rdy = 1'b0;
    #1;
    chk("bp_first_rd_rdy", 32'(rd_req_rdy), 32'd1);
    @(negedge clock);
    rd_req_addr = 27'h456;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rd_rdy", 32'(rd_req_rdy), 32'd0);
      chk("bp_app_en", 32'(app_en), 32'd1);
      chk("bp_app_cmd", 32'(app_cmd), 32'(CMD_RD));
      chk("bp_app_addr", 32'(app_addr), 32'h123);
      @(negedge clock);
    end
    app_rdy = 1'b1;
    #1;
    chk("bp_release_rd_rdy", 32'(rd_req_rdy), 32'd1);
    @(posedge clock); #1;
    chk("bp_release_addr", 32'(app_addr), 32'h456);
    $display("[TB] backpressure: released addr=0x%0h", app_addr);

    // credit saturation and sticky overflow
    do_reset();
    wdf_beat_done = 1'b1;
    repeat (63) @(negedge clock);
    chk("sat63_credit", 32'(dut.u_credit.credit_q), 32'd63);
    chk("sat63_ovf", 32'(credit_ovf), 32'd0);
    @(negedge clock);
    wdf_beat_done = 1'b0;
    chk("sat64_credit", 32'(dut.u_credit.credit_q), 32'd63);
    chk("sat64_ovf", 32'(credit_ovf), 32'd1);
    repeat (5) @(negedge clock);
    chk("ovf_sticky", 32'(credit_ovf), 32'd1);
    do_reset();
    chk("ovf_cleared", 32'(credit_ovf), 32'd0);
    chk("credit_cleared", 32'(dut.u_credit.credit_q), 32'd0);
    $display("[TB] saturation: ovf set after 64 beats, cleared by reset");

    // reset while a command is stalled in the slot
    do_reset();
    wdf_beat_done = 1'b1;
    @(negedge clock);
    wdf_beat_done = 1'b0;
    init_calib_complete = 1'b1; rd_req_vld = 1'b1; rd_req_addr = 27'h321; app_rdy = 1'b0;
    @(posedge clock); #1;
    chk("stall_app_en", 32'(app_en), 32'd1);
    @(negedge clock);
    rst_n = 1'b0; app_rdy = 1'b1;
    #1;
    chk("inrst_rd_rdy", 32'(rd_req_rdy), 32'd0);
    @(posedge clock); #1;
    chk("midrst_app_en", 32'(app_en), 32'd0);
    chk("midrst_state", 32'(dut.state_q), 32'(IDLE));
    chk("midrst_credit", 32'(dut.u_credit.credit_q), 32'd0);
    @(negedge clock);
    rst_n = 1'b1;
    clear_inputs();
    $display("[TB] mid-operation reset: slot discarded");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
